mult_unit: RTL and testbench

- Iterative shift-add multiplier in the EX stage, serving MIPS mult/multu.
- Owns the HI/LO register pair.
- Responder side of the multiply-stall handshake: the hazard unit stalls F/D and flushes E while start_mult or busy_mult is high.
- Results become visible in hi/lo only after busy_mult drops, so a stalled mfhi/mflo always reads the final product.

---
 rtl/mult_pkg.sv | 10 +
 rtl/mult_unit.sv | 94 +++++++++
 tb/tb_mult_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default sizing for the multiply unit
package mult_pkg;
    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNTW  = 6;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        FINISH = 2'b10
    } mult_state_t;
endpackage

// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add multiplier owning the HI/LO register pair
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNTW  = MULT_CNTW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             signed_mult,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy_mult,
    output logic             done_mult,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    mult_state_t        state_q, state_d;
    logic [CNTW-1:0]    cnt_q;
    logic [WIDTH-1:0]   mcand_q, mplier_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               neg_q, done_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] result;
    logic               last;

    assign a_mag  = (signed_mult && srca[WIDTH-1]) ? -srca : srca;
    assign b_mag  = (signed_mult && srcb[WIDTH-1]) ? -srcb : srcb;
    assign sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    assign result = neg_q ? -prod_q : prod_q;
    assign last   = (cnt_q == CNTW'(WIDTH - 1));

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state: one start accepted only from IDLE, WIDTH iterations, then a result cycle
    always_comb begin
        state_d = (state_q == IDLE) ? (start_mult ? BUSY : IDLE) :
                  (state_q == BUSY) ? (last ? FINISH : BUSY) : IDLE;
    end

    // busy is a pure decode of the registered state
    always_comb begin
        busy_mult = (state_q != IDLE);
    end

    // datapath: operand capture, shift-add iterations, sign correction and HI/LO writes
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == FINISH);
            case (state_q)
                IDLE: begin
                    if (start_mult) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        neg_q    <= signed_mult & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        prod_q   <= '0;
                        cnt_q    <= '0;
                    end
                    if (we_hi) hi_q <= wdata;
                    if (we_lo) lo_q <= wdata;
                end
                BUSY: begin
                    prod_q   <= {sum, prod_q[WIDTH-1:1]};
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNTW'(1);
                end
                FINISH: {hi_q, lo_q} <= result;
                default: ;
            endcase
        end
    end

    assign done_mult = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed scoreboard bench for the shift-add multiplier
module tb_mult_unit;
    logic        clk = 1'b0;
    logic        reset, start_mult, signed_mult, we_hi, we_lo;
    logic [31:0] srca, srcb, wdata, hi, lo;
    logic        busy_mult, done_mult;
    logic [63:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    mult_unit dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .signed_mult(signed_mult),
        .srca(srca), .srcb(srcb), .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .busy_mult(busy_mult), .done_mult(done_mult), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expected product
    always @(negedge clk) begin
        if (!reset && done_mult) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", hi, lo);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("product", {hi, lo}, e);
            end
        end
    end

    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic push, input logic [63:0] exp);
        start_mult  = 1'b1;
        signed_mult = s;
        srca        = a;
        srcb        = b;
        if (push) sb_q.push_back(exp);
        @(negedge clk);
        start_mult = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_mult && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {63'd0, done_mult}, 64'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1; start_mult = 1'b0; signed_mult = 1'b0;
        srca = '0; srcb = '0; we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, busy_mult}, 64'd0);
        chk("reset_done", {63'd0, done_mult}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        start_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001);
        n = 0;
        while (busy_mult && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'd33);
        chk("done_on_exit", {63'd0, done_mult}, 64'd1);
        @(negedge clk);
        chk("done_pulse_len", {63'd0, done_mult}, 64'd0);

        start_op(1'b1, 32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFEB);
        wait_done();
        @(negedge clk);
        start_op(1'b0, 32'hFFFFFFFD, 32'h00000007, 1'b1, 64'h00000006_FFFFFFEB);
        wait_done();
        @(negedge clk);
        start_op(1'b1, 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
        wait_done();
        @(negedge clk);
        start_op(1'b1, 32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000);
        wait_done();
        @(negedge clk);
        start_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001);
        wait_done();
        @(negedge clk);

        start_op(1'b0, 32'h00010000, 32'h00010000, 1'b1, 64'h00000001_00000000);
        repeat (4) @(negedge clk);
        start_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'd0);
        wait_done();
        start_op(1'b1, 32'h00000007, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFEB);
        chk("accept_in_done_cycle", {63'd0, busy_mult}, 64'd1);
        wait_done();
        @(negedge clk);

        start_op(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 64'd0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {63'd0, busy_mult}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        repeat (40) @(negedge clk);
        chk("abort_idle", {63'd0, busy_mult}, 64'd0);
        start_op(1'b1, 32'd2, 32'd3, 1'b1, 64'd6);
        wait_done();
        @(negedge clk);

        we_hi = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        we_hi = 1'b0;
        chk("mthi", {32'd0, hi}, {32'd0, 32'hDEADBEEF});
        we_lo = 1'b1; wdata = 32'h11111111;
        @(negedge clk);
        we_lo = 1'b0;
        chk("mtlo", {32'd0, lo}, {32'd0, 32'h11111111});
        we_hi = 1'b1; wdata = 32'h55AA55AA;
        start_op(1'b0, 32'd5, 32'd6, 1'b1, 64'd30);
        we_hi = 1'b0;
        chk("mthi_with_start", {32'd0, hi}, {32'd0, 32'h55AA55AA});
        chk("start_with_write_busy", {63'd0, busy_mult}, 64'd1);
        we_lo = 1'b1; wdata = 32'hCAFEF00D;
        @(negedge clk);
        we_lo = 1'b0;
        chk("mtlo_while_busy", {32'd0, lo}, {32'd0, 32'h11111111});
        wait_done();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end
endmodule
